// File: rtl/casez_seq_dispatch.sv
// Wildcard-match command dispatcher: first-match (value, don't-care mask) lookup at accept,
// followed by a timed wait / code update / hold sequence, or a default wait with a miss count on no match.
module casez_seq_dispatch #(
  parameter int WIDTH    = 4,
  parameter int NITEMS   = 3,
  parameter int CODE_W   = 4,
  parameter int PRE_CYC  = 3,
  parameter int POST_CYC = 3,
  parameter int DEF_CYC  = 2,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = (NITEMS > 1) ? $clog2(NITEMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NITEMS*WIDTH-1:0]  pat_val,
  input  logic [NITEMS*WIDTH-1:0]  pat_mask,
  input  logic [NITEMS*CODE_W-1:0] pat_code,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         match_idx,
  output logic                     hit,
  output logic                     done,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int MAXC_A = (PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC;
  localparam int MAXC   = (MAXC_A > DEF_CYC) ? MAXC_A : DEF_CYC;
  localparam int CYC_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DFLT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_lat_q, code_lat_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic              m_hit;
  logic [IDX_W-1:0]  m_idx;
  logic [CODE_W-1:0] m_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_code = '0;
    for (int i = NITEMS - 1; i >= 0; i--) begin
      if (((in_data ^ pat_val[i*WIDTH +: WIDTH]) & ~pat_mask[i*WIDTH +: WIDTH]) == '0) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(i);
        m_code = pat_code[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_lat_d  = code_lat_q;
    out_code_d  = out_code_q;
    out_valid_d = 1'b0;
    idx_d       = idx_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    miss_d      = miss_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          code_lat_d = m_code;
          idx_d      = m_idx;
          hit_d      = m_hit;
          if (m_hit) begin
            state_d = S_PRE;
            cnt_d   = CYC_W'(PRE_CYC - 1);
          end else begin
            state_d = S_DFLT;
            cnt_d   = CYC_W'(DEF_CYC - 1);
          end
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          out_code_d  = code_lat_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
          cnt_d       = CYC_W'(POST_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DFLT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          miss_d  = sat_inc(miss_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_lat_q  <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_lat_q  <= code_lat_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign match_idx = idx_q;
  assign hit       = hit_q;
  assign done      = done_q;
  assign miss_cnt  = miss_q;

endmodule

// File: doc/casez_seq_dispatch.md
Name: casez_seq_dispatch

Overview:
Clocked, parametrised wildcard-match dispatcher, the synthesizable successor to the behavioural casez-with-delays sequencer. Accepts a WIDTH-bit value over a valid/ready handshake and matches it against NITEMS runtime-programmable (value, don't-care mask) patterns with first-match priority. Executes a timed action per outcome: wait, update output code, hold. A miss runs a default wait and counts the miss. Used as a command decoder/sequencer in front of multi-cycle datapaths.

Parameters:
WIDTH, 4, bit width of in_data and of each pattern
NITEMS, 3, number of case items (patterns); minimum 1
CODE_W, 4, width of each item's output code
PRE_CYC, 3, cycles from accept to out_code update on a hit; minimum 1
POST_CYC, 3, hold cycles after out_code update before done; minimum 1
DEF_CYC, 2, cycles from accept to done on a miss; minimum 1
CNT_W, 8, width of miss counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block idle, can accept
in_data  in  WIDTH  value to match
pat_val  in  NITEMS*WIDTH  item i value at [i*WIDTH +: WIDTH]
pat_mask  in  NITEMS*WIDTH  1 = don't-care bit (casez z/?)
pat_code  in  NITEMS*CODE_W  item i code at [i*CODE_W +: CODE_W]
out_code  out  CODE_W  last written code (registered)
out_valid  out  1  one-cycle pulse: out_code just updated
match_idx  out  clog2(NITEMS) or 1  index of the matched item (registered at accept)
hit  out  1  1 = the last accepted request matched an item
done  out  1  one-cycle pulse: action complete
miss_cnt  out  CNT_W  saturating count of default-path requests

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_code=0, out_valid=0, match_idx=0, hit=0, done=0, miss_cnt=0, internal counter=0.
- Match: item i matches when ((in_data ^ pat_val[i]) & ~pat_mask[i]) == 0. The lowest matching index wins. Combinational on in_data/pat_*. Evaluated only at accept.
- Accept: at the rising edge E0 where in_valid & in_ready. On that edge, latch the code of the winning item, match_idx and hit. pat_* and in_data changes after E0 have no effect on the running action.
- FSM states: IDLE, PRE, HOLD, DFLT. in_ready = (state == IDLE).
- IDLE: on accept, go to PRE if hit, otherwise DFLT. Load the counter accordingly.
- PRE: at edge E0+PRE_CYC, out_code <= latched code. out_valid is high for exactly the following cycle. Go to HOLD.
- HOLD: at edge E0+PRE_CYC+POST_CYC, go to IDLE. done is high for exactly the following cycle, in which in_ready is also high.
- DFLT: at edge E0+DEF_CYC, go to IDLE and pulse done. out_code and out_valid are unchanged. miss_cnt increments and holds at all-ones (no wrap).
- Earliest next accept: edge E0+PRE_CYC+POST_CYC+1 on a hit, E0+DEF_CYC+1 on a miss. A same-cycle in_valid during the done cycle is accepted, giving back-to-back operation.
- in_valid while busy: ignored, not queued. The requester must hold in_valid until in_ready.
- out_code writing the same value still pulses out_valid.
- Reset mid-operation: immediate return to IDLE. All outputs return to reset values. No done pulse.
- No X/Z handling on in_data. Wildcarding exists only via pat_mask.

Test Plan:
- Defaults; patterns {0000/m0000/c0, 0001/m0010/c1, 0100/m0000/c2}. Accept in_data=0000 at E0 -> out_valid at cycle after E0+3, out_code=0, hit=1, match_idx=0, done after E0+6.
- in_data=0011 -> matches item1 via the don't-care bit: out_code=1 at E0+3, match_idx=1. Then in_data=0100 accepted at the done cycle -> out_code=2 three cycles later.
- Overlap priority: item0 mask=1111 -> any in_data gives match_idx=0, code 0.
- Miss in_data=1111 -> done after E0+2, out_code unchanged, out_valid never high, hit=0, miss_cnt 0->1. With CNT_W=2, 5 misses -> miss_cnt=3 (saturated).
- in_valid held during PRE with different pat_code, and pat_code changed at E0+1 -> no second accept; out_code equals the code latched at E0.
- rst_n low at E0+2 during PRE -> outputs zero asynchronously, no out_valid/done. After release, in_ready=1 and a new accept works normally.
